// File: rtl/popcount_frame_ctrl_if.sv
// Word stream in, frame result out: the handshake bundle of popcount_frame_ctrl.
interface popcount_frame_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_sum;
    logic [7:0]  out_words;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_words
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_words
    );
endinterface

// File: rtl/popcount_frame_ctrl.sv
// Counts set bits over a frame of 16-bit words through a PIPE_LAT-deep popcount
// pipeline and presents the frame total and word count with a valid/ready handshake.
module popcount_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int PIPE_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 busy,
    popcount_frame_ctrl_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int PC_W   = 5;
    localparam int SUM_W  = 13;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic        [PC_W-1:0]     pc_p  [PIPE_LAT];
    logic        [PIPE_LAT-1:0] vld_p;
    logic        [SUM_W-1:0]    acc;
    logic        [7:0]          word_cnt;
    logic        [8:0]          cnt_inc;
    logic                       accept;
    logic                       close_frame;
    logic                       pipe_empty;
    logic                       handshake;

    function automatic logic [PC_W-1:0] popcount16(input logic [DATA_W-1:0] w);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) n = n + {4'b0, w[i]};
        return n;
    endfunction

    assign accept      = bus.in_valid && (state == ACCUM);
    assign cnt_inc     = {1'b0, word_cnt} + 9'd1;
    assign close_frame = accept && ((cnt_inc == 9'(FRAME_LEN)) || bus.in_last);
    assign pipe_empty  = (vld_p == '0);
    assign handshake   = (state == HOLD) && bus.out_ready;

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = ACCUM;
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (close_frame) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_nxt = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                // enable is only looked at here and in IDLE, so a frame in flight always finishes
                if (bus.out_ready) state_nxt = enable ? ACCUM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stage p0: popcount of the accepted word; later stages only delay it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pc_p[i] <= '0;
        end else begin
            vld_p[0] <= accept;
            if (accept) pc_p[0] <= popcount16(bus.in_data);
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                pc_p[i]  <= pc_p[i-1];
            end
        end
    end

    // Final stage: accumulate; the result is captured when DRAIN sees an empty pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            word_cnt      <= '0;
            bus.out_sum   <= '0;
            bus.out_words <= '0;
        end else begin
            if (handshake) begin
                acc      <= '0;
                word_cnt <= '0;
            end else begin
                if (vld_p[PIPE_LAT-1]) acc <= acc + SUM_W'(pc_p[PIPE_LAT-1]);
                if (accept)            word_cnt <= cnt_inc[7:0];
            end
            if ((state == DRAIN) && pipe_empty) begin
                bus.out_sum   <= acc;
                bus.out_words <= word_cnt;
            end
        end
    end
endmodule

// File: tb/tb_popcount_frame_ctrl.sv
// Bench for popcount_frame_ctrl: directed frame table, multi-cycle corner sequences
// and random traffic checked against a frame-level reference model.
module tb_popcount_frame_ctrl;
    localparam int FRAME_LEN = 4;
    localparam int PIPE_LAT  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;

    popcount_frame_ctrl_if bus();

    popcount_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .PIPE_LAT(PIPE_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: running frame contents and the one outstanding result
    int m_sum, m_cnt, m_exp_sum, m_exp_words, m_due;
    bit m_pending;
    bit last_acc, seen_hs, seen_valid;
    int seen_sum, seen_words;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        close;
        int          sum;
        int          words;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon();
        bit exp_ov;
        last_acc   = 0;
        seen_hs    = 0;
        seen_valid = 0;
        if (!rst_n) begin
            m_sum = 0; m_cnt = 0; m_pending = 0;
            return;
        end
        if (m_pending) chk("in_ready_while_result_pending", int'(bus.in_ready), 0);
        exp_ov = m_pending && (cyc >= m_due);
        chk("out_valid_timing", int'(bus.out_valid), int'(exp_ov));
        if (bus.out_valid) begin
            seen_valid = 1;
            if (exp_ov) begin
                chk("model_out_sum", int'(bus.out_sum), m_exp_sum);
                chk("model_out_words", int'(bus.out_words), m_exp_words);
            end
            if (bus.out_ready) begin
                seen_hs    = 1;
                seen_sum   = int'(bus.out_sum);
                seen_words = int'(bus.out_words);
                m_pending  = 0;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            last_acc = 1;
            m_sum += $countones(bus.in_data);
            m_cnt++;
            if (m_cnt == FRAME_LEN || bus.in_last) begin
                m_pending   = 1;
                m_exp_sum   = m_sum;
                m_exp_words = m_cnt;
                m_due       = cyc + PIPE_LAT + 2;
                m_sum = 0; m_cnt = 0;
            end
        end
    endtask

    // one clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (last_acc) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input int es, input int ew, input int ready_after);
        bit got = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (seen_hs) begin got = 1; break; end
        end
        if (!got) chk("result_timeout", 0, 1);
        else begin
            chk("frame_out_sum", seen_sum, es);
            chk("frame_out_words", seen_words, ew);
            chk("in_ready_after_handshake", int'(bus.in_ready), ready_after);
        end
    endtask

    initial begin
        tbl[0]  = '{16'hFFFF, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{16'h0000, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{16'h0001, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{16'h8001, 1'b0, 1'b1, 19, 4};
        tbl[4]  = '{16'h00FF, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{16'h0F0F, 1'b1, 1'b1, 16, 2};
        tbl[6]  = '{16'hAAAA, 1'b1, 1'b1, 8, 1};
        tbl[7]  = '{16'h0000, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{16'h0000, 1'b0, 1'b0, 0, 0};
        tbl[9]  = '{16'h0000, 1'b0, 1'b0, 0, 0};
        tbl[10] = '{16'h0000, 1'b0, 1'b1, 0, 4};
        tbl[11] = '{16'hFFFF, 1'b0, 1'b0, 0, 0};
        tbl[12] = '{16'hFFFF, 1'b0, 1'b0, 0, 0};
        tbl[13] = '{16'hFFFF, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{16'hFFFF, 1'b0, 1'b1, 64, 4};

        rst_n = 1'b1; enable = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        #3 rst_n = 1'b0;
        tick(); tick();
        chk("reset_in_ready", int'(bus.in_ready), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_sum", int'(bus.out_sum), 0);
        chk("reset_out_words", int'(bus.out_words), 0);
        rst_n = 1'b1;

        // enable held low: block must stay idle
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_in_ready", int'(bus.in_ready), 0);
            chk("idle_busy", int'(busy), 0);
        end
        enable = 1'b1;
        tick();
        chk("start_in_ready", int'(bus.in_ready), 1);
        chk("start_busy", int'(busy), 1);

        for (int i = 0; i < 15; i++) begin
            send_word(tbl[i].data, tbl[i].last);
            if (tbl[i].close) wait_result(tbl[i].sum, tbl[i].words, 1);
        end
        // frame that follows the 64-bit frame immediately after its handshake
        for (int i = 11; i < 15; i++) begin
            send_word(tbl[i].data, tbl[i].last);
            if (tbl[i].close) wait_result(tbl[i].sum, tbl[i].words, 1);
        end

        // backpressure: result must hold steady for 6 cycles
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(16'h1111, 1'b0);
        begin
            bit got = 0;
            for (int n = 0; n < 20; n++) begin
                tick();
                if (seen_valid) begin got = 1; break; end
            end
            if (!got) chk("hold_timeout", 0, 1);
        end
        for (int i = 0; i < 6; i++) begin
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_out_sum", int'(bus.out_sum), 16);
            chk("hold_out_words", int'(bus.out_words), 4);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_result(16, 4, 1);

        // enable dropped mid-frame: frame completes, then back to idle
        send_word(16'h0101, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) send_word(16'h0101, 1'b0);
        wait_result(8, 4, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dropped_enable_busy", int'(busy), 0);
            chk("dropped_enable_in_ready", int'(bus.in_ready), 0);
        end
        enable = 1'b1;
        tick();

        // reset in the middle of a frame
        send_word(16'hFFFF, 1'b0);
        send_word(16'hFFFF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_in_ready", int'(bus.in_ready), 0);
        chk("async_reset_out_sum", int'(bus.out_sum), 0);
        chk("async_reset_out_words", int'(bus.out_words), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_word(16'h0003, 1'b0);
        wait_result(8, 4, 1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_data   = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            bus.in_last   = ($urandom_range(7) == 0);
            bus.out_ready = ($urandom_range(2) != 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("random_drained", int'(m_pending), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
